// File: rtl/amf_pkg.sv
// Shared definitions for the adaptive-median-filter result writer.
package amf_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wr_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = (value == 0) ? 0 : value - 1;
        while (rem != 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/result_writer_if.sv
// Pixel strobe input and image RAM write port of the result writer.
interface result_writer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  pixValid;
    logic [DATA_WIDTH-1:0] pixData;
    logic [ADDR_WIDTH-1:0] pixAddr;
    logic                  memReady;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memData;

    // Writer side: consumes pixels, masters the RAM write port.
    modport master (
        input  pixValid, pixData, pixAddr, memReady,
        output memWe, memAddr, memData
    );

    // Environment side: filter strobes pixels, RAM accepts writes.
    modport slave (
        output pixValid, pixData, pixAddr, memReady,
        input  memWe, memAddr, memData
    );
endinterface

// File: rtl/pixel_fifo.sv
// Small capture FIFO; pointers carry one extra wrap bit for full/empty.
module pixel_fifo
    import amf_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear flushes the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/result_writer.sv
// Result writer: buffers filtered pixels and drains them into the image RAM.
// Optional checksum output enabled with `define WRITER_CHECKSUM_EN.
module result_writer
    import amf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          M,
    input  logic [15:0]          N,
    input  logic                 lastF,
    result_writer_if.master      bus,
    output logic                 full,
    output logic                 overflow,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pixCount
`ifdef WRITER_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);
    localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;

    wr_state_e            state;
    wr_state_e            state_nx;
    logic [CNT_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0] target_c;
    logic [CNT_WIDTH-1:0] cnt_inc_c;
    logic [EW-1:0]        fifo_head;
    logic                 fifo_empty;
    logic                 clear_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 drop_c;

    assign target_c  = CNT_WIDTH'(32'(M) * 32'(N));
    assign cnt_inc_c = (pixCount == '1) ? pixCount : pixCount + CNT_WIDTH'(1);

    pixel_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_c),
        .push  (push_c),
        .wdata ({bus.pixAddr, bus.pixData}),
        .pop   (pop_c),
        .rdata (fifo_head),
        .full  (full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and per-edge control: start always wins, pixels only move in RUN.
    always_comb begin
        state_nx = state;
        clear_c  = 1'b0;
        push_c   = 1'b0;
        pop_c    = 1'b0;
        drop_c   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear_c  = 1'b1;
                    state_nx = (target_c == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (start) begin
                    clear_c  = 1'b1;
                    state_nx = (target_c == '0) ? DONE : RUN;
                end else begin
                    pop_c  = !fifo_empty && bus.memReady;
                    push_c = bus.pixValid && (!full || pop_c);
                    drop_c = bus.pixValid && full && !pop_c;
                    if ((pop_c && (cnt_inc_c == target)) ||
                        (lastF && fifo_empty && !bus.pixValid)) begin
                        state_nx = DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write register, counters and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.memWe   <= 1'b0;
            bus.memAddr <= '0;
            bus.memData <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            pixCount    <= '0;
            target      <= '0;
        end else begin
            bus.memWe <= pop_c;
            done      <= (state_nx == DONE);
            if (clear_c) begin
                overflow <= 1'b0;
                pixCount <= '0;
                target   <= target_c;
            end
            if (drop_c) overflow <= 1'b1;
            if (pop_c) begin
                bus.memAddr <= fifo_head[EW-1 -: ADDR_WIDTH];
                bus.memData <= fifo_head[DATA_WIDTH-1:0];
                pixCount    <= cnt_inc_c;
            end
        end
    end

`ifdef WRITER_CHECKSUM_EN
    // Running 16-bit sum of every data word written to the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         checksum <= '0;
        else if (clear_c) checksum <= '0;
        else if (pop_c)   checksum <= checksum + 16'(fifo_head[DATA_WIDTH-1:0]);
    end
`endif

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Sink for the adaptive-median-filter datapath. It captures each filtered pixel/address pair strobed out of the filter and buffers it in a small FIFO.
- It drains the FIFO into the output image RAM through a write port with ready backpressure.
- It counts written pixels against the M x N frame size and flags frame completion to the controller.

Parameters:
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 8, image RAM address width
- FIFO_DEPTH, 4, capture FIFO entries (power of two, >= 2)
- CNT_WIDTH, 16, written-pixel counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin/restart frame
- M  in  16  image rows
- N  in  16  image columns
- pixValid  in  1  one-cycle strobe: pixData/pixAddr valid
- pixData  in  DATA_WIDTH  filtered pixel
- pixAddr  in  ADDR_WIDTH  pixel address
- lastF  in  1  filter's last-pixel flag (level)
- memReady  in  1  RAM can accept a write this cycle
- memWe  out  1  RAM write enable
- memAddr  out  ADDR_WIDTH  RAM write address
- memData  out  DATA_WIDTH  RAM write data
- full  out  1  FIFO full
- overflow  out  1  sticky: a pixel was dropped
- done  out  1  frame fully written
- pixCount  out  CNT_WIDTH  pixels written this frame

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; FIFO is emptied.
  - memWe, memAddr, memData, overflow, done and pixCount all reset to 0; full resets to 0.
- FSM states: IDLE, RUN, DONE. Encoding is 2 bits.
- IDLE:
  - pixValid is ignored.
  - start goes to RUN. On that edge: clear FIFO, pixCount, overflow, done; latch target = M*N truncated to CNT_WIDTH.
  - If the latched target is 0, go directly to DONE instead.
- RUN, push:
  - pixValid with FIFO not full enqueues {pixAddr, pixData} at the edge.
  - If the FIFO is full and no pop happens that edge, the pixel is dropped and overflow is set to 1 (sticky until start or reset).
  - If full and a pop happens the same edge, the push is accepted.
- RUN, pop:
  - If the FIFO is not empty and memReady=1, at the edge: dequeue the head, register it onto memAddr/memData, set memWe=1, and increment pixCount.
  - Otherwise memWe=0 and memAddr/memData hold their last values.
- Latency: a pixel strobed at edge k appears with memWe=1 after edge k+1 at the earliest (FIFO empty, memReady=1).
- Throughput: 1 pixel/cycle with memReady held high.
- RUN to DONE at the edge where either:
  - the write making pixCount == target is issued; or
  - lastF=1, the FIFO is empty and no push is pending (early-terminated frame).
- On entering DONE, memWe is deasserted at the following edge.
- DONE:
  - done=1; pixValid is ignored; pixCount holds.
  - start goes to RUN with the same clearing as from IDLE.
- start while in RUN aborts the frame: FIFO is flushed, counters are cleared, target is re-latched, and state stays RUN. An in-flight memWe completes for that cycle only.
- full = (FIFO occupancy == FIFO_DEPTH), combinational from the registered pointers.
- pixCount saturates at its maximum value and does not wrap.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit each; full and empty are derived from the wrap bit.
- Reset mid-write: all outputs go to 0 immediately, asynchronously.

Optional Feature:
- Macro: WRITER_CHECKSUM_EN.
- Defined: adds output port checksum [15:0].
  - Reset to 0 and cleared on start.
  - On each issued write, adds zero-extended memData modulo 2^16, registered in the same edge as memWe.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package amf_pkg holds:
  - default DATA_WIDTH / ADDR_WIDTH / CNT_WIDTH constants;
  - the writer state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper function.
- Sub-module pixel_fifo: parameterised DATA_WIDTH+ADDR_WIDTH wide, FIFO_DEPTH deep; push/pop/full/empty; same clk/rst.
- result_writer contains the FSM, counter and write register.

Test Plan:
- M=2, N=2, start; 4 pixValid on consecutive cycles (addr 0..3, data 8'h10..8'h13); memReady=1 -> 4 writes on consecutive cycles, each 1 cycle after its push; pixCount=4; done=1 one edge after the 4th write.
- memReady=0, 5 pixValid strobes with FIFO_DEPTH=4 -> full=1 after the 4th; the 5th is dropped and overflow=1; raise memReady -> exactly 4 writes, addresses in push order.
- FIFO full, pixValid and pop in the same cycle -> push accepted, overflow stays 0, occupancy stays 4.
- M=3, N=3; 5 pixels written, then lastF=1 with the FIFO empty -> DONE with pixCount=5, done=1.
- Restart at pixCount=2 in RUN -> FIFO empties, pixCount=0, new frame of 4 completes normally. Repeat with M=0 -> done=1 one edge after start, no writes.
- WRITER_CHECKSUM_EN defined: data 8'hFF x 300 writes (M=15, N=20) -> checksum = 300*255 mod 65536 = 16'h2AD4 (76500 - 65536 = 10964 = 0x2AD4).
